// File: rtl/iopmp_err_capture.sv
// rtl/iopmp_err_capture.sv - IOPMP error-report capture, first-fault record, irq and TL-UL denial response
// Optional feature macro: IOPMP_MFR_EN (multi-fault record windows, ERR_MFR read port)
module iopmp_err_capture #(
  parameter int ADDR_W   = 34,
  parameter int RRID_W   = 16,
  parameter int SRC_W    = 8,
  parameter int SZ_W     = 2,
  parameter int RRID_NUM = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rep_valid_i,
  output logic              rep_ready_o,
  input  logic [1:0]        rep_ttype_i,
  input  logic [2:0]        rep_etype_i,
  input  logic [ADDR_W-1:0] rep_addr_i,
  input  logic [RRID_W-1:0] rep_rrid_i,
  input  logic [15:0]       rep_eid_i,
  input  logic              rep_sup_irq_i,
  input  logic              rep_sup_err_i,
  input  logic [SRC_W-1:0]  rep_src_i,
  input  logic [SZ_W-1:0]   rep_size_i,
  input  logic [7:0]        cfg_i,
  input  logic              v_clr_i,
  output logic [31:0]       reqinfo_o,
  output logic [31:0]       reqaddr_o,
  output logic [31:0]       reqaddrh_o,
  output logic [31:0]       reqid_o,
  output logic              irq_o,
  output logic              d_valid_o,
  input  logic              d_ready_i,
  output logic [2:0]        d_opcode_o,
  output logic              d_error_o,
  output logic [SRC_W-1:0]  d_source_o,
  output logic [SZ_W-1:0]   d_size_o,
`ifdef IOPMP_MFR_EN
  output logic [31:0]       err_mfr_o,
  input  logic              mfr_rd_i,
`endif
  output logic [31:0]       d_data_o
);

  typedef enum logic {ST_IDLE, ST_RESP} state_e;

  localparam logic RRID_NUM_OK = ((RRID_NUM % 16) == 0);

  state_e state_q, state_d;

  logic        accept;
  logic        recordable;
  logic        v_eff;
  logic        capture;
  logic        sv_hit;
  logic        ty_ie;
  logic        ty_re;
  logic        resp_op;
  logic        resp_err;
  logic        svc;
  logic [31:0] addr_hi;

  logic              v_q;
  logic [1:0]        ttype_q;
  logic [2:0]        etype_q;
  logic [31:0]       addr_lo_q;
  logic [31:0]       addr_hi_q;
  logic [RRID_W-1:0] rrid_q;
  logic [15:0]       eid_q;
  logic              irq_q;

  logic              op_q;
  logic              err_q;
  logic [SRC_W-1:0]  src_q;
  logic [SZ_W-1:0]   size_q;

  assign rep_ready_o = (state_q == ST_IDLE);
  assign accept      = rep_valid_i & rep_ready_o;
  assign recordable  = (rep_ttype_i != 2'b00);
  // A clear in the same cycle as an accept frees the record for the new fault
  assign v_eff       = v_q & ~v_clr_i;
  assign capture     = accept & recordable & ~v_eff;
  assign sv_hit      = accept & recordable & v_eff;

  generate
    if (ADDR_W > 34) begin : g_addr_hi
      assign addr_hi = 32'(rep_addr_i[ADDR_W-1:34]);
    end else begin : g_addr_hi_zero
      assign addr_hi = 32'h0;
    end
  endgenerate

  // Report FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Report FSM next state: accept in IDLE, hold response until D handshake
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = ST_RESP;
      ST_RESP: if (d_ready_i) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Select per-transaction-type irq/response enables and response opcode
  always_comb begin
    ty_ie   = 1'b0;
    ty_re   = 1'b0;
    resp_op = 1'b0;
    case (rep_ttype_i)
      2'b01: begin ty_ie = cfg_i[2]; ty_re = cfg_i[5]; resp_op = 1'b1; end
      2'b10: begin ty_ie = cfg_i[3]; ty_re = cfg_i[6]; resp_op = 1'b0; end
      2'b11: begin ty_ie = cfg_i[4]; ty_re = cfg_i[7]; resp_op = 1'b1; end
      default: begin ty_ie = 1'b0; ty_re = 1'b0; resp_op = 1'b0; end
    endcase
  end

  // Reserved ttype always gets a bus error; otherwise error unless suppressed
  assign resp_err = ~recordable | (~rep_sup_err_i & ~ty_re);

  // D-channel response fields latched at accept, held stable through RESP
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      op_q   <= 1'b0;
      err_q  <= 1'b0;
      src_q  <= '0;
      size_q <= '0;
    end else if (accept) begin
      op_q   <= resp_op;
      err_q  <= resp_err;
      src_q  <= rep_src_i;
      size_q <= rep_size_i;
    end
  end

  // First-fault record; a clear drops only v, fields hold until next capture
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v_q       <= 1'b0;
      ttype_q   <= 2'b00;
      etype_q   <= 3'b000;
      addr_lo_q <= 32'h0;
      addr_hi_q <= 32'h0;
      rrid_q    <= '0;
      eid_q     <= 16'h0;
    end else begin
      if (v_clr_i) v_q <= 1'b0;
      if (capture) begin
        v_q       <= 1'b1;
        ttype_q   <= rep_ttype_i;
        etype_q   <= rep_etype_i;
        addr_lo_q <= rep_addr_i[33:2];
        addr_hi_q <= addr_hi;
        rrid_q    <= rep_rrid_i;
        eid_q     <= rep_eid_i;
      end
    end
  end

  // Level irq: set by an enabled, unsuppressed capture; held while v; ie gates it
  always_ff @(posedge clk_i) begin
    if (!rst_ni) irq_q <= 1'b0;
    else         irq_q <= cfg_i[1] & ((irq_q & ~v_clr_i) |
                                      (capture & ty_ie & ~rep_sup_irq_i));
  end

`ifdef IOPMP_MFR_EN
  localparam int NWIN  = RRID_NUM / 16;
  localparam int WIN_W = (NWIN > 1) ? $clog2(NWIN) : 1;

  logic [RRID_NUM-1:0] svw_q;
  logic [RRID_NUM-1:0] svw_set;
  logic [RRID_NUM-1:0] svw_clr;
  logic [WIN_W-1:0]    svi_q;
  logic [31:0]         mfr_q;
  logic                found;
  logic [WIN_W-1:0]    found_idx;
  logic [15:0]         found_win;
  int                  j;

  // Scan windows forward from svi with wrap; build set/clear masks
  always_comb begin
    found     = 1'b0;
    found_idx = '0;
    found_win = 16'h0;
    j         = 0;
    svw_set   = '0;
    svw_clr   = '0;
    for (int i = 0; i < NWIN; i++) begin
      j = int'(svi_q) + i;
      if (j >= NWIN) j = j - NWIN;
      if (!found && (svw_q[j*16 +: 16] != 16'h0)) begin
        found     = 1'b1;
        found_idx = WIN_W'(j);
        found_win = svw_q[j*16 +: 16];
      end
    end
    if (mfr_rd_i && found) begin
      for (int w = 0; w < NWIN; w++) begin
        if (w == int'(found_idx)) svw_clr[w*16 +: 16] = 16'hFFFF;
      end
    end
    if (sv_hit && (int'(rep_rrid_i) < RRID_NUM)) begin
      svw_set = RRID_NUM'(1) << rep_rrid_i;
    end
  end

  // Subsequent-violation windows and ERR_MFR read-out register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      svw_q <= '0;
      svi_q <= '0;
      mfr_q <= 32'h0;
    end else begin
      svw_q <= (svw_q & ~svw_clr) | svw_set;
      if (mfr_rd_i) begin
        mfr_q <= {found, 3'b000, 12'(found ? found_idx : svi_q), found_win};
        if (found) svi_q <= found_idx;
      end
    end
  end

  assign svc       = |svw_q;
  assign err_mfr_o = mfr_q;

  logic unused_bits;
  assign unused_bits = ^{rep_addr_i[1:0], cfg_i[0], RRID_NUM_OK};
`else
  assign svc = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{rep_addr_i[1:0], cfg_i[0], RRID_NUM_OK, sv_hit};
`endif

  assign reqinfo_o  = {24'h0, svc, etype_q, 1'b0, ttype_q, v_q};
  assign reqaddr_o  = addr_lo_q;
  assign reqaddrh_o = addr_hi_q;
  assign reqid_o    = {eid_q, 16'(rrid_q)};
  assign irq_o      = irq_q;

  assign d_valid_o  = (state_q == ST_RESP);
  assign d_opcode_o = {2'b00, op_q};
  assign d_error_o  = err_q;
  assign d_source_o = src_q;
  assign d_size_o   = size_q;
  assign d_data_o   = 32'h0;

endmodule

// File: tb/tb_iopmp_err_capture.sv
// tb/tb_iopmp_err_capture.sv - directed table-driven bench for iopmp_err_capture
module tb_iopmp_err_capture;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        rep_valid_i;
  logic        rep_ready_o;
  logic [1:0]  rep_ttype_i;
  logic [2:0]  rep_etype_i;
  logic [33:0] rep_addr_i;
  logic [15:0] rep_rrid_i;
  logic [15:0] rep_eid_i;
  logic        rep_sup_irq_i;
  logic        rep_sup_err_i;
  logic [7:0]  rep_src_i;
  logic [1:0]  rep_size_i;
  logic [7:0]  cfg_i;
  logic        v_clr_i;
  logic [31:0] reqinfo_o;
  logic [31:0] reqaddr_o;
  logic [31:0] reqaddrh_o;
  logic [31:0] reqid_o;
  logic        irq_o;
  logic        d_valid_o;
  logic        d_ready_i;
  logic [2:0]  d_opcode_o;
  logic        d_error_o;
  logic [7:0]  d_source_o;
  logic [1:0]  d_size_o;
  logic [31:0] d_data_o;

  iopmp_err_capture dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rep_valid_i(rep_valid_i), .rep_ready_o(rep_ready_o),
    .rep_ttype_i(rep_ttype_i), .rep_etype_i(rep_etype_i),
    .rep_addr_i(rep_addr_i), .rep_rrid_i(rep_rrid_i), .rep_eid_i(rep_eid_i),
    .rep_sup_irq_i(rep_sup_irq_i), .rep_sup_err_i(rep_sup_err_i),
    .rep_src_i(rep_src_i), .rep_size_i(rep_size_i),
    .cfg_i(cfg_i), .v_clr_i(v_clr_i),
    .reqinfo_o(reqinfo_o), .reqaddr_o(reqaddr_o), .reqaddrh_o(reqaddrh_o),
    .reqid_o(reqid_o), .irq_o(irq_o),
    .d_valid_o(d_valid_o), .d_ready_i(d_ready_i),
    .d_opcode_o(d_opcode_o), .d_error_o(d_error_o),
    .d_source_o(d_source_o), .d_size_o(d_size_o), .d_data_o(d_data_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        clr;
    logic [1:0]  tt;
    logic [2:0]  et;
    logic [33:0] addr;
    logic [15:0] rrid;
    logic [15:0] eid;
    logic        sirq;
    logic        serr;
    logic [7:0]  cfg;
    logic        op;
    logic        err;
    logic [31:0] info;
    logic [31:0] ra;
    logic [31:0] rid;
    logic        irq;
  } vec_t;

  vec_t vt[9];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] tt, input logic [2:0] et, input logic [33:0] a,
                       input logic [15:0] rr, input logic [15:0] e, input logic si,
                       input logic se, input logic [7:0] s, input logic [1:0] sz,
                       input logic [7:0] c);
    rep_ttype_i   = tt;
    rep_etype_i   = et;
    rep_addr_i    = a;
    rep_rrid_i    = rr;
    rep_eid_i     = e;
    rep_sup_irq_i = si;
    rep_sup_err_i = se;
    rep_src_i     = s;
    rep_size_i    = sz;
    cfg_i         = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //        clr  tt     et    addr             rrid      eid       sirq  serr  cfg    op    err   info    ra            rid           irq
    vt[0] = '{1'b0, 2'd1, 3'd1, 34'h1_2345_6788, 16'h0003, 16'h0005, 1'b0, 1'b0, 8'h06, 1'b1, 1'b1, 32'h13, 32'h48D159E2, 32'h00050003, 1'b1};
    vt[1] = '{1'b0, 2'd2, 3'd2, 34'h0_0000_1000, 16'h0007, 16'h0009, 1'b0, 1'b0, 8'h06, 1'b0, 1'b1, 32'h13, 32'h48D159E2, 32'h00050003, 1'b1};
    vt[2] = '{1'b1, 2'd2, 3'd3, 34'h2_0000_0010, 16'h000A, 16'h0002, 1'b0, 1'b1, 8'h0E, 1'b0, 1'b0, 32'h35, 32'h80000004, 32'h0002000A, 1'b1};
    vt[3] = '{1'b1, 2'd2, 3'd4, 34'h0_0000_0104, 16'h0001, 16'h0011, 1'b0, 1'b0, 8'h42, 1'b0, 1'b0, 32'h45, 32'h00000041, 32'h00110001, 1'b0};
    vt[4] = '{1'b1, 2'd3, 3'd5, 34'h3_FFFF_FFFC, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 8'h12, 1'b1, 1'b1, 32'h57, 32'hFFFFFFFF, 32'h1234FFFF, 1'b0};
    vt[5] = '{1'b1, 2'd3, 3'd6, 34'h0_0000_0008, 16'h0002, 16'h0000, 1'b0, 1'b0, 8'h92, 1'b1, 1'b0, 32'h67, 32'h00000002, 32'h00000002, 1'b1};
    vt[6] = '{1'b1, 2'd0, 3'd7, 34'h0_0000_0F00, 16'h0009, 16'h0003, 1'b0, 1'b0, 8'h92, 1'b0, 1'b1, 32'h66, 32'h00000002, 32'h00000002, 1'b0};
    vt[7] = '{1'b1, 2'd1, 3'd7, 34'h0_0000_0100, 16'h0004, 16'h0008, 1'b0, 1'b0, 8'h04, 1'b1, 1'b1, 32'h73, 32'h00000040, 32'h00080004, 1'b0};
    vt[8] = '{1'b1, 2'd1, 3'd1, 34'h0_0000_0200, 16'h0005, 16'h0001, 1'b0, 1'b0, 8'h26, 1'b1, 1'b0, 32'h13, 32'h00000080, 32'h00010005, 1'b1};

    rst_ni = 1'b0;
    rep_valid_i = 1'b0;
    v_clr_i = 1'b0;
    d_ready_i = 1'b0;
    drive(2'd0, 3'd0, 34'h0, 16'h0, 16'h0, 1'b0, 1'b0, 8'h0, 2'd0, 8'h00);
    tick();
    tick();
    chk("rst_d_valid", 64'(d_valid_o), 64'h0);
    chk("rst_ready", 64'(rep_ready_o), 64'h1);
    chk("rst_reqinfo", 64'(reqinfo_o), 64'h0);
    chk("rst_reqaddr", 64'(reqaddr_o), 64'h0);
    chk("rst_reqaddrh", 64'(reqaddrh_o), 64'h0);
    chk("rst_reqid", 64'(reqid_o), 64'h0);
    chk("rst_irq", 64'(irq_o), 64'h0);
    chk("rst_d_error", 64'(d_error_o), 64'h0);
    rst_ni = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      if (vt[i].clr) begin
        v_clr_i = 1'b1;
        tick();
        v_clr_i = 1'b0;
        if (i > 0) chk($sformatf("v%0d_clr_info", i), 64'(reqinfo_o), 64'(vt[i-1].info & 32'hFFFF_FFFE));
        chk($sformatf("v%0d_clr_irq", i), 64'(irq_o), 64'h0);
      end
      drive(vt[i].tt, vt[i].et, vt[i].addr, vt[i].rrid, vt[i].eid, vt[i].sirq,
            vt[i].serr, 8'(8'h10 + i), 2'(i), vt[i].cfg);
      rep_valid_i = 1'b1;
      d_ready_i = 1'b0;
      chk($sformatf("v%0d_ready", i), 64'(rep_ready_o), 64'h1);
      tick();
      rep_valid_i = 1'b0;
      chk($sformatf("v%0d_d_valid", i), 64'(d_valid_o), 64'h1);
      chk($sformatf("v%0d_busy", i), 64'(rep_ready_o), 64'h0);
      if (vt[i].tt != 2'd0) chk($sformatf("v%0d_opcode", i), 64'(d_opcode_o), 64'(vt[i].op));
      chk($sformatf("v%0d_error", i), 64'(d_error_o), 64'(vt[i].err));
      chk($sformatf("v%0d_source", i), 64'(d_source_o), 64'(8'h10 + i));
      chk($sformatf("v%0d_size", i), 64'(d_size_o), 64'(i % 4));
      chk($sformatf("v%0d_data", i), 64'(d_data_o), 64'h0);
      chk($sformatf("v%0d_reqinfo", i), 64'(reqinfo_o), 64'(vt[i].info));
      chk($sformatf("v%0d_reqaddr", i), 64'(reqaddr_o), 64'(vt[i].ra));
      chk($sformatf("v%0d_reqaddrh", i), 64'(reqaddrh_o), 64'h0);
      chk($sformatf("v%0d_reqid", i), 64'(reqid_o), 64'(vt[i].rid));
      chk($sformatf("v%0d_irq", i), 64'(irq_o), 64'(vt[i].irq));
      d_ready_i = 1'b1;
      tick();
      d_ready_i = 1'b0;
      chk($sformatf("v%0d_d_done", i), 64'(d_valid_o), 64'h0);
    end

    // D-channel stall: response stable, no accepts, resume after handshake
    drive(2'd2, 3'd2, 34'h0_0000_0800, 16'h000C, 16'h000D, 1'b0, 1'b0, 8'hAA, 2'd1, 8'h06);
    rep_valid_i = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d_valid", k), 64'(d_valid_o), 64'h1);
      chk($sformatf("stall%0d_ready", k), 64'(rep_ready_o), 64'h0);
      chk($sformatf("stall%0d_resp", k), 64'({d_opcode_o, d_error_o, d_source_o, d_size_o}),
          64'({3'd0, 1'b1, 8'hAA, 2'd1}));
      rep_src_i = 8'(8'hB0 + k);
      tick();
    end
    chk("stall_record_kept", 64'(reqinfo_o), 64'h13);
    chk("stall_reqaddr_kept", 64'(reqaddr_o), 64'h80);
    rep_src_i = 8'hBB;
    d_ready_i = 1'b1;
    tick();
    d_ready_i = 1'b0;
    chk("hs_valid_low", 64'(d_valid_o), 64'h0);
    chk("hs_ready_high", 64'(rep_ready_o), 64'h1);
    tick();
    rep_valid_i = 1'b0;
    chk("resume_valid", 64'(d_valid_o), 64'h1);
    chk("resume_source", 64'(d_source_o), 64'hBB);
    d_ready_i = 1'b1;
    tick();
    d_ready_i = 1'b0;

    // Clear and accept in the same cycle: new record captured, v and irq stay high
    chk("pre_clr_irq", 64'(irq_o), 64'h1);
    drive(2'd1, 3'd2, 34'h0_0000_0400, 16'h0006, 16'h0007, 1'b0, 1'b0, 8'h21, 2'd2, 8'h06);
    rep_valid_i = 1'b1;
    v_clr_i = 1'b1;
    tick();
    rep_valid_i = 1'b0;
    v_clr_i = 1'b0;
    chk("clracc_reqinfo", 64'(reqinfo_o), 64'h23);
    chk("clracc_reqaddr", 64'(reqaddr_o), 64'h100);
    chk("clracc_reqid", 64'(reqid_o), 64'h00070006);
    chk("clracc_irq", 64'(irq_o), 64'h1);
    d_ready_i = 1'b1;
    tick();
    d_ready_i = 1'b0;

    // Reset while a response is pending drops it
    drive(2'd1, 3'd1, 34'h0_0000_0040, 16'h0001, 16'h0001, 1'b0, 1'b0, 8'h33, 2'd0, 8'h06);
    rep_valid_i = 1'b1;
    tick();
    rep_valid_i = 1'b0;
    chk("mid_valid", 64'(d_valid_o), 64'h1);
    rst_ni = 1'b0;
    tick();
    chk("midrst_valid", 64'(d_valid_o), 64'h0);
    chk("midrst_v", 64'(reqinfo_o[0]), 64'h0);
    chk("midrst_irq", 64'(irq_o), 64'h0);
    chk("midrst_ready", 64'(rep_ready_o), 64'h1);
    rst_ni = 1'b1;
    tick();
    chk("post_rst_valid", 64'(d_valid_o), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
